// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for one shared external ALU.
// Accepted operations are latched, executed for one cycle and returned on a tagged response port.
module alu_req_arbiter #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [3:0]   req0_op_code,
    input  logic [N-1:0] req0_operand1,
    input  logic [N-1:0] req0_operand2,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [3:0]   req1_op_code,
    input  logic [N-1:0] req1_operand1,
    input  logic [N-1:0] req1_operand2,

    output logic [3:0]   alu_op_code,
    output logic [N-1:0] alu_operand1,
    output logic [N-1:0] alu_operand2,
    input  logic [N-1:0] alu_result,
    input  logic         alu_zero,
    input  logic         alu_overflow,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_zero,
    output logic         rsp_overflow,
    output logic         rsp_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           last_grant;
    logic           grant;
    logic           accept;

    logic [3:0]     op_p0;
    logic [N-1:0]   opa_p0;
    logic [N-1:0]   opb_p0;
    logic           id_p0;

    function automatic logic op_legal(input logic [3:0] op);
        return (op <= 4'd9);
    endfunction

    // Contention goes to whoever did not win last time.
    always_comb begin
        grant = ~last_grant;
        if (req0_valid && !req1_valid) begin
            grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:                   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: latched request, the only source of the ALU inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            id_p0      <= 1'b0;
            op_p0      <= '0;
            opa_p0     <= '0;
            opb_p0     <= '0;
        end else if (accept) begin
            last_grant <= grant;
            id_p0      <= grant;
            op_p0      <= grant ? req1_op_code  : req0_op_code;
            opa_p0     <= grant ? req1_operand1 : req0_operand1;
            opb_p0     <= grant ? req1_operand2 : req0_operand2;
        end
    end

    assign alu_op_code  = op_p0;
    assign alu_operand1 = opa_p0;
    assign alu_operand2 = opb_p0;

    // Stage p1: registered response; illegal ops never expose ALU output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_error    <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid <= 1'b1;
            rsp_id    <= id_p0;
            if (op_legal(op_p0)) begin
                rsp_result   <= alu_result;
                rsp_zero     <= alu_zero;
                rsp_overflow <= alu_overflow;
                rsp_error    <= 1'b0;
            end else begin
                rsp_result   <= '0;
                rsp_zero     <= 1'b1;
                rsp_overflow <= 1'b0;
                rsp_error    <= 1'b1;
            end
        end else if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: reference ALU, vector table, scoreboard and arbitration/backpressure/reset sequences.
module tb_alu_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready;
    logic [3:0]  req0_op_code;
    logic [31:0] req0_operand1, req0_operand2;
    logic        req1_valid, req1_ready;
    logic [3:0]  req1_op_code;
    logic [31:0] req1_operand1, req1_operand2;
    logic [3:0]  alu_op_code;
    logic [31:0] alu_operand1, alu_operand2, alu_result;
    logic        alu_zero, alu_overflow;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_overflow, rsp_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          id;
        logic [31:0] res;
        bit          z;
        bit          ov;
        bit          err;
    } exp_t;

    typedef struct {
        bit          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          z;
        bit          ov;
        bit          err;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[13];

    always #5 clk = ~clk;

    alu_req_arbiter #(.N(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op_code(req0_op_code),
        .req0_operand1(req0_operand1), .req0_operand2(req0_operand2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op_code(req1_op_code),
        .req1_operand1(req1_operand1), .req1_operand2(req1_operand2),
        .alu_op_code(alu_op_code), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
        .rsp_error(rsp_error)
    );

    // Reference ALU; illegal codes return junk so any leak into the response is visible.
    always_comb begin
        alu_result   = 32'd0;
        alu_overflow = 1'b0;
        case (alu_op_code)
            4'd0: alu_result = alu_operand2 << alu_operand1[4:0];
            4'd1: alu_result = alu_operand2 >> alu_operand1[4:0];
            4'd2: alu_result = $signed(alu_operand2) >>> alu_operand1[4:0];
            4'd3: begin
                alu_result   = alu_operand1 + alu_operand2;
                alu_overflow = (alu_operand1[31] == alu_operand2[31]) && (alu_result[31] != alu_operand1[31]);
            end
            4'd4: begin
                alu_result   = alu_operand1 - alu_operand2;
                alu_overflow = (alu_operand1[31] != alu_operand2[31]) && (alu_result[31] != alu_operand1[31]);
            end
            4'd5: alu_result = alu_operand1 & alu_operand2;
            4'd6: alu_result = alu_operand1 | alu_operand2;
            4'd7: alu_result = alu_operand1 ^ alu_operand2;
            4'd8: alu_result = ~(alu_operand1 | alu_operand2);
            4'd9: alu_result = {31'd0, ($signed(alu_operand1) < $signed(alu_operand2))};
            default: begin
                alu_result   = 32'hDEADBEEF;
                alu_overflow = 1'b1;
            end
        endcase
        alu_zero = (alu_op_code <= 4'd9) && (alu_result == 32'd0);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic checkb(input string nm, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0b required=%0b", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input bit id, input logic [31:0] res, input bit z, input bit ov, input bit err);
        exp_t e;
        e.id = id; e.res = res; e.z = z; e.ov = ov; e.err = err;
        sbq.push_back(e);
    endtask

    // Scoreboard: compare every response at its handshake.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sbq.size() == 0) begin
                checkb("sb_unexpected_rsp", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkb("sb_id", rsp_id, e.id);
                check("sb_result", rsp_result, e.res);
                checkb("sb_zero", rsp_zero, e.z);
                checkb("sb_overflow", rsp_overflow, e.ov);
                checkb("sb_error", rsp_error, e.err);
            end
        end
    end

    task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        if (id) begin
            req1_valid = 1'b1; req1_op_code = op; req1_operand1 = a; req1_operand2 = b;
        end else begin
            req0_valid = 1'b1; req0_op_code = op; req0_operand1 = a; req0_operand2 = b;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) checkb("issue_timeout", 1'b1, 1'b0);
        tick();
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_empty(input string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check(nm, sbq.size(), 0);
    endtask

    initial begin
        bit got[$];
        int n;

        vt[0]  = '{1'b0, 4'd3,  32'd5,        32'd7,        32'd12,       1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 4'd4,  32'd9,        32'd9,        32'd0,        1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 4'd6,  32'hF0,       32'h0F,       32'hFF,       1'b0, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 4'd12, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 4'd0,  32'd4,        32'd1,        32'd16,       1'b0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 4'd1,  32'd4,        32'h80000000, 32'h08000000, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 4'd2,  32'd4,        32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 4'd5,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 4'd7,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 4'd8,  32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vt[10] = '{1'b1, 4'd9,  32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1'b0};
        vt[11] = '{1'b0, 4'd3,  32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b1, 1'b0};
        vt[12] = '{1'b1, 4'd4,  32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};

        reset = 1'b1;
        req0_valid = 1'b0; req0_op_code = 4'd0; req0_operand1 = 32'd0; req0_operand2 = 32'd0;
        req1_valid = 1'b0; req1_op_code = 4'd0; req1_operand1 = 32'd0; req1_operand2 = 32'd0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        checkb("rst_rsp_valid", rsp_valid, 1'b0);
        checkb("rst_rsp_id", rsp_id, 1'b0);
        check("rst_rsp_result", rsp_result, 32'd0);
        checkb("rst_rsp_zero", rsp_zero, 1'b0);
        checkb("rst_rsp_overflow", rsp_overflow, 1'b0);
        checkb("rst_rsp_error", rsp_error, 1'b0);
        check("rst_alu_op_code", 32'(alu_op_code), 32'd0);
        check("rst_alu_operand1", alu_operand1, 32'd0);
        check("rst_alu_operand2", alu_operand2, 32'd0);
        reset = 1'b0;
        tick();

        // Both requesters held valid from reset: expect grants 0,1,0,1.
        expect_rsp(1'b0, 32'd0,  1'b1, 1'b0, 1'b0);
        expect_rsp(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
        expect_rsp(1'b0, 32'd0,  1'b1, 1'b0, 1'b0);
        expect_rsp(1'b1, 32'hFF, 1'b0, 1'b0, 1'b0);
        req0_valid = 1'b1; req0_op_code = 4'd4; req0_operand1 = 32'd9;   req0_operand2 = 32'd9;
        req1_valid = 1'b1; req1_op_code = 4'd6; req1_operand1 = 32'hF0; req1_operand2 = 32'h0F;
        #1;
        n = 0;
        while (got.size() < 4 && n < 60) begin
            checkb("arb_one_ready", req0_ready && req1_ready, 1'b0);
            if (req0_ready || req1_ready) got.push_back(req1_ready);
            tick();
            n++;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("arb_grant_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) begin
            checkb("arb_grant_order", got[i], (i % 2) == 1);
        end
        wait_empty("arb_drain");

        // Vector table, one operation at a time with rsp_ready high.
        for (int i = 0; i < 13; i++) begin
            expect_rsp(vt[i].id, vt[i].res, vt[i].z, vt[i].ov, vt[i].err);
            issue(vt[i].id, vt[i].op, vt[i].a, vt[i].b);
            checkb("vec_exec_no_rsp", rsp_valid, 1'b0);
            check("vec_alu_op_code", 32'(alu_op_code), 32'(vt[i].op));
            check("vec_alu_operand1", alu_operand1, vt[i].a);
            check("vec_alu_operand2", alu_operand2, vt[i].b);
            tick();
            checkb("vec_latency_rsp_valid", rsp_valid, 1'b1);
            tick();
            checkb("vec_consumed", rsp_valid, 1'b0);
            checkb("vec_error_cleared", rsp_error, 1'b0);
        end
        check("vec_drain", sbq.size(), 0);

        // Backpressure: response held five cycles, no grants meanwhile.
        rsp_ready = 1'b0;
        expect_rsp(1'b0, 32'd7, 1'b0, 1'b0, 1'b0);
        expect_rsp(1'b1, 32'd2, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 4'd3, 32'd3, 32'd4);
        tick();
        req1_valid = 1'b1; req1_op_code = 4'd5; req1_operand1 = 32'd6; req1_operand2 = 32'd3;
        #1;
        for (int c = 0; c < 5; c++) begin
            checkb("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_result", rsp_result, 32'd7);
            checkb("bp_rsp_id", rsp_id, 1'b0);
            checkb("bp_req0_ready", req0_ready, 1'b0);
            checkb("bp_req1_ready", req1_ready, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        checkb("bp_first_accept", req1_ready, 1'b1);
        tick();
        req1_valid = 1'b0;
        wait_empty("bp_drain");

        // Reset pulsed while an operation is in EXEC.
        expect_rsp(1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
        issue(1'b0, 4'd3, 32'd1, 32'd2);
        reset = 1'b1;
        #1;
        checkb("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_alu_op_code", 32'(alu_op_code), 32'd0);
        check("mid_rst_alu_operand1", alu_operand1, 32'd0);
        check("mid_rst_alu_operand2", alu_operand2, 32'd0);
        sbq.delete();
        #1;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkb("post_rst_no_rsp", rsp_valid, 1'b0);
        end
        expect_rsp(1'b0, 32'hC, 1'b0, 1'b0, 1'b0);
        req0_valid = 1'b1; req0_op_code = 4'd7; req0_operand1 = 32'hF; req0_operand2 = 32'h3;
        req1_valid = 1'b1; req1_op_code = 4'd3; req1_operand1 = 32'd1; req1_operand2 = 32'd1;
        #1;
        checkb("post_rst_req0_ready", req0_ready, 1'b1);
        checkb("post_rst_req1_ready", req1_ready, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_empty("post_rst_drain");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
